lsu_arbiter: RTL and testbench

LSU_ARBITER -- requirements
Module: lsu_arbiter

---
 rtl/lsu_arbiter.sv | 156 +++++++++++++++
 tb/tb_lsu_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lsu_arbiter
// Brief    : Two-master round-robin arbiter between the core LSU (m0) and the
//            Montgomery accelerator LSU (m1) onto the dp_ram A port.
//            Optional watchdog abort compiled in with LSU_ARB_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module lsu_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_ren,
    input  logic        m0_wen,
    input  logic [1:0]  m0_type,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_done,
    input  logic        m1_ren,
    input  logic        m1_wen,
    input  logic [1:0]  m1_type,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_done,
    output logic        mem_valid,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        bus_err
);

    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
        $error("lsu_arbiter: TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY0 = 2'd1,
        S_BUSY1 = 2'd2,
        S_TURN  = 2'd3
    } state_t;

    state_t      state_q;
    logic        rr_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  type_q;
    logic        wen_q;

    logic        w_req0;
    logic        w_req1;
    logic        w_pick1;
    logic        w_busy;
    logic        w_gnt1;
    logic        w_abort;
    logic        w_finish;
    logic [3:0]  w_strb;
    logic [31:0] w_wdata_fmt;

    assign w_req0   = m0_ren | m0_wen;
    assign w_req1   = m1_ren | m1_wen;
    // m1 wins only when m0 is idle or the round-robin pointer favours m1
    assign w_pick1  = w_req1 & (~w_req0 | rr_q);
    assign w_busy   = (state_q == S_BUSY0) || (state_q == S_BUSY1);
    assign w_gnt1   = (state_q == S_BUSY1);
    assign w_finish = w_busy & (mem_ready | w_abort);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            rr_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            type_q  <= 2'd0;
            wen_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_req0 | w_req1) begin
                        state_q <= w_pick1 ? S_BUSY1 : S_BUSY0;
                        addr_q  <= w_pick1 ? m1_addr  : m0_addr;
                        wdata_q <= w_pick1 ? m1_wdata : m0_wdata;
                        type_q  <= w_pick1 ? m1_type  : m0_type;
                        wen_q   <= w_pick1 ? m1_wen   : m0_wen;
                    end
                end
                S_BUSY0, S_BUSY1: begin
                    if (w_finish) begin
                        state_q <= S_TURN;
                        rr_q    <= ~w_gnt1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef LSU_ARB_TIMEOUT_EN
    localparam logic [7:0] C_TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wdog_q;

    // Held at zero while idle, so every BUSY phase starts counting from 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_q <= 8'd0;
        end else if (state_q == S_IDLE) begin
            wdog_q <= 8'd0;
        end else if (w_busy && !mem_ready) begin
            wdog_q <= wdog_q + 8'd1;
        end
    end

    // A ready in the final allowed cycle still completes normally
    assign w_abort = w_busy & ~mem_ready & (wdog_q == C_TO_LAST);
`else
    assign w_abort = 1'b0;
`endif

    always_comb begin
        w_strb      = 4'b1111;
        w_wdata_fmt = wdata_q;
        case (type_q)
            2'b00: begin
                w_strb      = 4'b0001 << addr_q[1:0];
                w_wdata_fmt = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                w_strb      = 4'b0011 << {addr_q[1], 1'b0};
                w_wdata_fmt = {2{wdata_q[15:0]}};
            end
            default: begin
                w_strb      = 4'b1111;
                w_wdata_fmt = wdata_q;
            end
        endcase
    end

    assign mem_valid = w_busy;
    assign mem_addr  = w_busy ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem_we    = (w_busy && wen_q) ? w_strb : 4'b0000;
    assign mem_wdata = w_busy ? w_wdata_fmt : 32'd0;

    assign m0_done   = w_finish & ~w_gnt1;
    assign m1_done   = w_finish & w_gnt1;
    assign m0_rdata  = ((state_q == S_BUSY0) && !w_abort) ? mem_rdata : 32'd0;
    assign m1_rdata  = ((state_q == S_BUSY1) && !w_abort) ? mem_rdata : 32'd0;
    assign bus_err   = w_abort;

endmodule
`default_nettype wire

// File: tb/tb_lsu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_arbiter
// Brief    : Self-checking bench for lsu_arbiter: directed vector table,
//            corner sequences and randomized traffic against a reference model.
// Revision : 1.0
// ============================================================================
module tb_lsu_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_ren, m0_wen, m1_ren, m1_wen;
    logic [1:0]  m0_type, m1_type;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_done, m1_done;
    logic        mem_valid, mem_ready, bus_err;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    lsu_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_ren(m0_ren), .m0_wen(m0_wen), .m0_type(m0_type), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_done(m0_done),
        .m1_ren(m1_ren), .m1_wen(m1_wen), .m1_type(m1_type), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_done(m1_done),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .bus_err(bus_err)
    );

    typedef struct {
        logic        ren;
        logic        wen;
        logic [1:0]  typ;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
        int          start;
    } req_t;

    typedef struct {
        req_t        r0;
        req_t        r1;
        int          first;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } vec_t;

    int total = 0;
    int bad   = 0;
    bit favor;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    function automatic req_t mk(input logic ren, input logic wen, input logic [1:0] typ,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int lat, input int start);
        req_t r;
        r.ren = ren; r.wen = wen; r.typ = typ; r.addr = addr;
        r.wdata = wdata; r.rdata = rdata; r.lat = lat; r.start = start;
        return r;
    endfunction

    // Byte-lane arithmetic: lane index is the byte offset within the word
    function automatic logic [3:0] ref_strb(input logic wr, input logic [1:0] t, input logic [31:0] a);
        int off = int'(a % 4);
        if (!wr) return 4'd0;
        if (t == 2'd0) return 4'(1 << off);
        if (t == 2'd1) return 4'(3 << ((off / 2) * 2));
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] t, input logic [31:0] w);
        if (t == 2'd0) return (w % 256) * 32'h0101_0101;
        if (t == 2'd1) return (w % 65536) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic done_of(input int m);
        return (m == 1) ? m1_done : m0_done;
    endfunction

    function automatic logic [31:0] rdata_of(input int m);
        return (m == 1) ? m1_rdata : m0_rdata;
    endfunction

    task automatic drive(input int m, input bit on, input req_t r, input bit scr);
        logic [31:0] a = r.addr;
        logic [31:0] w = r.wdata;
        logic [1:0]  t = r.typ;
        if (scr) begin
            a = $urandom; w = $urandom; t = 2'($urandom_range(0, 3));
        end
        if (m == 0) begin
            m0_ren = on & r.ren; m0_wen = on & r.wen;
            m0_addr = on ? a : 32'd0; m0_wdata = on ? w : 32'd0; m0_type = on ? t : 2'd0;
        end else begin
            m1_ren = on & r.ren; m1_wen = on & r.wen;
            m1_addr = on ? a : 32'd0; m1_wdata = on ? w : 32'd0; m1_type = on ? t : 2'd0;
        end
    endtask

    // Runs until every requesting master has been served; reports the first grant.
    task automatic run(input req_t r0, input req_t r1, input bit scr, output int fm,
                       output logic [3:0] fwe, output logic [31:0] fa, output logic [31:0] fw);
        req_t r[2];
        bit pend[2], act[2], prev_act[2];
        bit wait_other = 0;
        int cur = -1, bcyc = 0, gap = -1, e;
        r[0] = r0; r[1] = r1;
        pend[0] = r0.ren | r0.wen; pend[1] = r1.ren | r1.wen;
        prev_act[0] = 0; prev_act[1] = 0;
        fm = -1; fwe = 4'd0; fa = 32'd0; fw = 32'd0;
        for (int c = 0; c < 300 && (pend[0] || pend[1]); c++) begin
            @(negedge clk);
            mem_rdata = $urandom;
            mem_ready = 1'b0;
            if (mem_valid && cur < 0) begin
                if (prev_act[0] && prev_act[1]) e = int'(favor);
                else if (prev_act[1]) e = 1;
                else if (prev_act[0]) e = 0;
                else e = -1;
                chk("grant_has_request", 32'(e >= 0), 32'd1);
                cur = (e < 0) ? 0 : e;
                bcyc = 0;
                if (wait_other) chk("turnaround_gap", 32'(gap), 32'd2);
                wait_other = 0;
                chk("grant_addr", mem_addr, r[cur].addr & 32'hFFFF_FFFC);
                chk("grant_we", 32'(mem_we), 32'(ref_strb(r[cur].wen, r[cur].typ, r[cur].addr)));
                if (r[cur].wen) chk("grant_wdata", mem_wdata, ref_wdata(r[cur].typ, r[cur].wdata));
                if (fm < 0) begin
                    fm = cur; fwe = mem_we; fa = mem_addr; fw = mem_wdata;
                end
            end
            if (!mem_valid && gap >= 0) gap++;
            if (!mem_valid && cur >= 0) chk("valid_dropped", 32'(mem_valid), 32'd1);
            if (mem_valid && cur >= 0) begin
                bcyc++;
                mem_ready = (bcyc == r[cur].lat + 1);
                if (mem_ready) mem_rdata = r[cur].rdata;
            end
            for (int m = 0; m < 2; m++) begin
                act[m] = pend[m] && (c >= r[m].start);
                drive(m, act[m], r[m], scr && (m == cur));
            end
            #1;
            if (cur >= 0 && mem_valid) begin
                if (mem_ready) begin
                    chk("done", 32'(done_of(cur)), 32'd1);
                    chk("other_done", 32'(done_of(1 - cur)), 32'd0);
                    chk("rdata", rdata_of(cur), r[cur].rdata);
                    chk("other_rdata", rdata_of(1 - cur), 32'd0);
                    chk("bus_err", 32'(bus_err), 32'd0);
                    pend[cur] = 0;
                    favor = (cur == 0);
                    wait_other = act[1 - cur];
                    gap = 0;
                    cur = -1;
                end else begin
                    chk("early_done", 32'({m0_done, m1_done}), 32'd0);
                end
            end
            prev_act = act;
        end
        chk("run_complete", 32'({pend[0], pend[1]}), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(mem_valid), 32'd0);
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_addr"}, mem_addr, 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_done"}, 32'({m0_done, m1_done}), 32'd0);
        chk({tag, "_m0_rdata"}, m0_rdata, 32'd0);
        chk({tag, "_m1_rdata"}, m1_rdata, 32'd0);
        chk({tag, "_bus_err"}, 32'(bus_err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: got=expired want=finished");
        $fatal(1, "time limit");
    end

    initial begin
        vec_t v[8];
        req_t none, ra, rb;
        int fm;
        logic [3:0] fwe;
        logic [31:0] fa, fw;
        int k;

        none = mk(0, 0, 2'd0, 32'd0, 32'd0, 32'd0, 0, 0);
        // Vectors run in order; the expected first grant depends on the rr history
        v[0] = '{mk(0, 1, 2'd2, 32'h10, 32'hCAFE_F00D, 32'h1, 0, 0),
                 mk(1, 0, 2'd2, 32'h24, 32'h0, 32'h2222_3333, 1, 0), 0, 4'hF, 32'h10, 32'hCAFE_F00D};
        v[1] = '{none, mk(1, 0, 2'd2, 32'h20, 32'h0, 32'hDEAD_BEEF, 1, 0), 1, 4'h0, 32'h20, 32'h0};
        v[2] = '{mk(0, 1, 2'd0, 32'h33, 32'hA5, 32'h0, 0, 0), none, 0, 4'b1000, 32'h30, 32'hA5A5_A5A5};
        v[3] = '{mk(1, 0, 2'd2, 32'h40, 32'h0, 32'h4444_0000, 0, 0),
                 mk(0, 1, 2'd1, 32'h32, 32'h1234, 32'h0, 2, 0), 1, 4'b1100, 32'h30, 32'h1234_1234};
        v[4] = '{mk(0, 1, 2'd1, 32'h31, 32'hFFFF_5678, 32'h0, 0, 0), none, 0, 4'b0011, 32'h30, 32'h5678_5678};
        v[5] = '{mk(1, 1, 2'd3, 32'h7, 32'h1122_3344, 32'h0, 1, 0), none, 0, 4'hF, 32'h4, 32'h1122_3344};
        v[6] = '{none, mk(0, 1, 2'd1, 32'h1, 32'hBEEF_CAFE, 32'h0, 0, 0), 1, 4'b0011, 32'h0, 32'hCAFE_CAFE};
        v[7] = '{mk(0, 1, 2'd0, 32'h102, 32'h5A, 32'h0, 2, 0), none, 0, 4'b0100, 32'h100, 32'h5A5A_5A5A};

        rst = 1'b1;
        drive(0, 1, mk(1, 1, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0), 0);
        drive(1, 1, mk(1, 1, 2'd1, 32'h1234_5677, 32'h9999_9999, 0, 0, 0), 0);
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, none, 0);
        drive(1, 0, none, 0);
        mem_ready = 1'b0;
        favor = 0;

        for (int i = 0; i < 8; i++) begin
            run(v[i].r0, v[i].r1, 0, fm, fwe, fa, fw);
            chk($sformatf("vec%0d_first", i), 32'(fm), 32'(v[i].first));
            chk($sformatf("vec%0d_we", i), 32'(fwe), 32'(v[i].we));
            chk($sformatf("vec%0d_addr", i), fa, v[i].addr);
            chk($sformatf("vec%0d_wdata", i), fw, v[i].wdata);
        end

        // m1 raises its request in the very cycle m0 completes
        run(mk(1, 0, 2'd2, 32'h50, 32'h0, 32'h5050_5050, 2, 0),
            mk(0, 1, 2'd2, 32'h54, 32'h7777_8888, 32'h0, 0, 3), 0, fm, fwe, fa, fw);
        chk("late_req_first", 32'(fm), 32'd0);

        for (int i = 0; i < 40; i++) begin
            ra = mk(1'($urandom), 1'($urandom), 2'($urandom_range(0, 3)), $urandom, $urandom,
                    $urandom, $urandom_range(0, 2), $urandom_range(0, 3));
            rb = mk(1'($urandom), 1'($urandom), 2'($urandom_range(0, 3)), $urandom, $urandom,
                    $urandom, $urandom_range(0, 2), $urandom_range(0, 3));
            if (!(ra.ren | ra.wen)) ra.ren = 1'b1;
            run(ra, rb, 1, fm, fwe, fa, fw);
        end

`ifdef LSU_ARB_TIMEOUT_EN
        @(negedge clk);
        @(negedge clk);
        drive(0, 1, mk(1, 0, 2'd2, 32'h80, 32'h0, 32'h0, 0, 0), 0);
        drive(1, 0, none, 0);
        mem_ready = 1'b0;
        k = 0;
        while (!mem_valid && k < 6) begin
            @(negedge clk);
            k++;
        end
        chk("to_valid", 32'(mem_valid), 32'd1);
        for (int b = 1; b <= TO; b++) begin
            if (b > 1) @(negedge clk);
            mem_rdata = 32'hABCD_0123;
            #1;
            chk($sformatf("to_done_c%0d", b), 32'(m0_done), 32'(b == TO));
            chk($sformatf("to_err_c%0d", b), 32'(bus_err), 32'(b == TO));
            if (b == TO) chk("to_rdata", m0_rdata, 32'd0);
        end
        favor = 1;
        @(negedge clk);
        drive(0, 0, none, 0);
        #1;
        chk("to_err_pulse", 32'(bus_err), 32'd0);
`endif

        @(negedge clk);
        drive(0, 0, none, 0);
        drive(1, 1, mk(1, 0, 2'd2, 32'h44, 32'h0, 32'h0, 0, 0), 0);
        mem_ready = 1'b0;
        k = 0;
        while (!mem_valid && k < 6) begin
            @(negedge clk);
            k++;
        end
        chk("rst_mid_valid", 32'(mem_valid), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        mem_ready = 1'b1;
        mem_rdata = 32'h1111_2222;
        #1;
        chk("rst_mid_ready_done", 32'(m1_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 0, none, 0);
        mem_ready = 1'b0;
        favor = 0;
        run(none, mk(1, 0, 2'd2, 32'h44, 32'h0, 32'h600D_F00D, 1, 0), 0, fm, fwe, fa, fw);
        chk("after_rst_first", 32'(fm), 32'd1);
        chk("after_rst_addr", fa, 32'h44);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
